gin_pe_input_fifo: RTL and testbench
====================================

# gin_pe_input_fifo

Per-PE input buffer on the consumer side of a GIN X-bus. It accepts `{enable, value}` words from its multicast controller slot, with one instance per PE. It stores them in a DEPTH-entry first-word-fall-through FIFO and presents them to the PE datapath over a valid/ready handshake. Its `gin_ready` output drives the controller's per-master ready, so bus back-pressure is exactly FIFO occupancy.

## Interface

Parameters:
- `VALUE_LEN`, default 32, payload width; must match the X-bus `VALUE_LEN`.
- `DEPTH`, default 4, number of entries; must be a power of two, at least 2.
- `AF_LEVEL`, default 3, occupancy at or above which `almost_full` asserts; legal range 1..DEPTH.

Ports (widths use CW = $clog2(DEPTH+1)):
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, reset; synchronous and active-high.
- `gin_enable_data`, input, VALUE_LEN+1, bus word from the controller; bit [VALUE_LEN] is enable, bits [VALUE_LEN-1:0] are the value.
- `gin_ready`, output, 1, to the controller's master-ready input; high when the FIFO can accept a word.
- `pe_valid`, output, 1, head entry is valid.
- `pe_data`, output, VALUE_LEN, head entry value.
- `pe_ready`, input, 1, PE consumes the head entry this cycle.
- `clear`, input, 1, synchronous flush with no reset of configuration.
- `count`, output, CW, current occupancy.
- `almost_full`, output, 1, asserted when `count >= AF_LEVEL`.

## Operation

- Storage: DEPTH x VALUE_LEN register array, plus write and read pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH.
- Occupancy: tracked in a separate `count` register, 0..DEPTH.
- Push: occurs when `gin_enable_data[VALUE_LEN] && gin_ready`. The value is written at the write pointer, then the write pointer advances.
- Hold on back-pressure: enable high with `gin_ready` low means no push. The bus holds the word; this is legal and not an error.
- Pop: occurs when `pe_valid && pe_ready`. The read pointer advances. `pe_ready` while empty is ignored.
- `gin_ready` equals `count != DEPTH`.
  - It is decoded from registered state only, with no combinational path from `pe_ready`. This keeps the bus-wide AND-reduced ready path short.
  - Consequence: when full, a same-cycle pop does not open the bus; `gin_ready` rises in the following cycle.
- `pe_valid` equals `count != 0`. `pe_data` equals `mem[rd_ptr]` (first-word fall-through).
- Push and pop in the same cycle: both pointers advance and `count` is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- Push into empty plus a `pe_ready` in the same cycle: no pop happens, because `pe_valid` was 0. `count` becomes 1.
- `clear`: both pointers and `count` go to 0 next cycle. Any push or pop in the same cycle is discarded. `clear` has priority over push and pop.
- `rst` has priority over everything. Reset values:
  - pointers 0 and `count` 0;
  - `gin_ready` 1, `pe_valid` 0, `almost_full` 0;
  - `pe_data` is don't-care, but must not be X-propagating into control;
  - memory contents are not reset.
- Reset mid-operation: all stored words are lost, and the controller sees `gin_ready` 1 in the cycle after reset deasserts. A reset pulse of one cycle suffices.

## Timing

- Push-to-visible latency: 1 cycle. A word pushed at edge N appears on `pe_valid`/`pe_data` after edge N. There is no bypass path from `gin_enable_data` to `pe_data`.
- Full-to-ready latency: 1 cycle after the pop edge.
- Throughput: 1 push and 1 pop per cycle sustained while 0 < count < DEPTH.
- `count` and `almost_full` are registered or decoded from registered state, and update on the same edge as the pointers.

## Test plan

- Reset then single word:
  - Stimulus: hold `rst` 1 for 2 cycles; push enable=1, value=0xDEADBEEF with `pe_ready`=0.
  - Required: `gin_ready`=1 after reset. One cycle later, `pe_valid`=1, `pe_data`=0xDEADBEEF, `count`=1.
- Fill to full, DEPTH=4:
  - Stimulus: push 1,2,3,4 back-to-back with `pe_ready`=0, then present 5.
  - Required: `almost_full` rises when `count`=3. `gin_ready`=0 at `count`=4, and 5 is held, not stored.
  - Then pulse `pe_ready` once. Required: `gin_ready` returns to 1 one cycle later, 5 is accepted, and the drain order is 2,3,4,5.
- Streaming with wrap-around:
  - Stimulus: 20 consecutive pushes 0..19 with `pe_ready`=1 continuously.
  - Required: the PE receives 0..19 in order, one per cycle after the first; `count` never exceeds 1; pointers wrap at least 4 times.
- Empty boundary:
  - Stimulus: `pe_ready`=1 with the FIFO empty for 3 cycles, then push 0x7 with `pe_ready`=1.
  - Required: `count` stays 0 with no pop, then becomes 1. The word pops on the following cycle.
- Clear priority:
  - Stimulus: with `count`=3, assert `clear` together with a push of 0xA and `pe_ready`=1.
  - Required: next cycle `count`=0, `pe_valid`=0, `gin_ready`=1, and 0xA is never delivered.
- Reset mid-stream:
  - Stimulus: with `count`=2, assert `rst` for 1 cycle while enable=1.
  - Required: `count`=0, `pe_valid`=0; the held bus word is accepted on the first cycle after reset.

Source files
------------

// File: rtl/gin_pe_input_fifo.sv
// Per-PE first-word-fall-through input buffer on the consumer side of a GIN X-bus.
// Bus back-pressure (gin_ready) is decoded purely from registered occupancy.
module gin_pe_input_fifo #(
   parameter int VALUE_LEN = 32,
   parameter int DEPTH     = 4,
   parameter int AF_LEVEL  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [VALUE_LEN:0]           gin_enable_data,
   output logic                         gin_ready,
   output logic                         pe_valid,
   output logic [VALUE_LEN-1:0]         pe_data,
   input  logic                         pe_ready,
   input  logic                         clear,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

   logic [VALUE_LEN-1:0] mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 push;
   logic                 pop;

   // Ready depends only on the count register, keeping the bus-wide ready AND short.
   assign gin_ready   = (count != DEPTH_CNT);
   assign pe_valid    = (count != '0);
   assign pe_data     = mem[rd_ptr];
   assign almost_full = (count >= AF_CNT);

   assign push = gin_enable_data[VALUE_LEN] && gin_ready;
   assign pop  = pe_valid && pe_ready;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push && !clear && !rst) mem[wr_ptr] <= gin_enable_data[VALUE_LEN-1:0];
   end

endmodule

// File: tb/tb_gin_pe_input_fifo.sv
// Scoreboard bench for gin_pe_input_fifo: a queue model tracks the expected contents
// and every delivered word is compared against the queue head.
module tb_gin_pe_input_fifo;

   localparam int VALUE_LEN = 32;
   localparam int DEPTH     = 4;
   localparam int AF_LEVEL  = 3;
   localparam int CW        = $clog2(DEPTH+1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [VALUE_LEN-1:0] val;
   logic [VALUE_LEN:0]   gin_enable_data;
   logic                 gin_ready;
   logic                 pe_valid;
   logic [VALUE_LEN-1:0] pe_data;
   logic                 pe_ready;
   logic                 clear;
   logic [CW-1:0]        count;
   logic                 almost_full;

   logic [31:0] q[$];
   logic [31:0] got[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          max_cnt;

   assign gin_enable_data = {en, val};

   always #5 clk = ~clk;

   gin_pe_input_fifo #(
      .VALUE_LEN(VALUE_LEN),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .gin_enable_data(gin_enable_data),
      .gin_ready      (gin_ready),
      .pe_valid       (pe_valid),
      .pe_data        (pe_data),
      .pe_ready       (pe_ready),
      .clear          (clear),
      .count          (count),
      .almost_full    (almost_full)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check outputs against the model, then advance model and DUT by one edge.
   task automatic cycle();
      logic do_push, do_pop;
      chk("count",       64'(count),       64'(q.size()));
      chk("gin_ready",   64'(gin_ready),   64'(q.size() != DEPTH));
      chk("pe_valid",    64'(pe_valid),    64'(q.size() != 0));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= AF_LEVEL));
      do_pop  = (q.size() != 0) && pe_ready;
      do_push = en && (q.size() != DEPTH);
      if (do_pop) chk("pe_data", 64'(pe_data), 64'(q[0]));
      if (rst || clear) begin
         q.delete();
      end else begin
         if (do_pop) got.push_back(q.pop_front());
         if (do_push) q.push_back(val);
      end
      if (q.size() > max_cnt) max_cnt = q.size();
      tick();
   endtask

   task automatic chk_got(input string tag, input logic [31:0] exp[$]);
      chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk(tag, 64'(got[i]), 64'(exp[i]));
      got.delete();
   endtask

   task automatic idle();
      en = 1'b0; val = '0; pe_ready = 1'b0; clear = 1'b0; rst = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_q[$];
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset then single word
      chk("rst_gin_ready", 64'(gin_ready), 64'd1);
      chk("rst_count", 64'(count), 64'd0);
      en = 1'b1; val = 32'hDEADBEEF;
      cycle();
      idle();
      chk("single_valid", 64'(pe_valid), 64'd1);
      chk("single_data", 64'(pe_data), 64'hDEADBEEF);
      chk("single_count", 64'(count), 64'd1);
      pe_ready = 1'b1;
      cycle();
      idle();
      cycle();
      exp_q = '{32'hDEADBEEF};
      chk_got("single_got", exp_q);

      // Fill to full, hold 5, then single pop opens the bus a cycle later
      for (int i = 1; i <= 4; i++) begin
         en = 1'b1; val = 32'(i);
         cycle();
      end
      val = 32'd5;
      cycle();
      chk("full_af", 64'(almost_full), 64'd1);
      pe_ready = 1'b1;
      cycle();
      pe_ready = 1'b0;
      chk("reopen_ready", 64'(gin_ready), 64'd1);
      cycle();
      en = 1'b0;
      pe_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      idle();
      exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
      chk_got("fill_order", exp_q);

      // Streaming with wrap-around
      max_cnt = 0;
      pe_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         en = 1'b1; val = 32'(i);
         cycle();
      end
      en = 1'b0;
      cycle();
      idle();
      chk("stream_max_count", 64'(max_cnt), 64'd1);
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(32'(i));
      chk_got("stream_order", exp_q);

      // Empty boundary: pe_ready on empty is ignored
      pe_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      en = 1'b1; val = 32'h7;
      cycle();
      en = 1'b0;
      chk("empty_push_count", 64'(count), 64'd1);
      cycle();
      idle();
      chk("empty_drained", 64'(count), 64'd0);
      exp_q = '{32'h7};
      chk_got("empty_got", exp_q);

      // Clear priority over simultaneous push and pop
      for (int i = 0; i < 3; i++) begin
         en = 1'b1; val = 32'h11 + 32'(i);
         cycle();
      end
      clear = 1'b1; en = 1'b1; val = 32'hA; pe_ready = 1'b1;
      cycle();
      clear = 1'b0; en = 1'b0;
      chk("clear_count", 64'(count), 64'd0);
      chk("clear_valid", 64'(pe_valid), 64'd0);
      chk("clear_ready", 64'(gin_ready), 64'd1);
      cycle();
      cycle();
      idle();
      exp_q.delete();
      chk_got("clear_got", exp_q);

      // Reset mid-stream with the bus holding a word
      for (int i = 0; i < 2; i++) begin
         en = 1'b1; val = 32'h21 + 32'(i);
         cycle();
      end
      rst = 1'b1; en = 1'b1; val = 32'h55;
      cycle();
      rst = 1'b0;
      chk("mrst_count", 64'(count), 64'd0);
      chk("mrst_valid", 64'(pe_valid), 64'd0);
      cycle();
      en = 1'b0; pe_ready = 1'b1;
      cycle();
      idle();
      cycle();
      exp_q = '{32'h55};
      chk_got("mrst_got", exp_q);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
